// File: rtl/load_extract_unit.sv
// Load extract unit: issues an aligned doubleword read, then extracts and extends the addressed byte/half/word/dword.
// Optional feature macro MISALIGN_TRAP_EN: misaligned requests return resp_err without touching memory.
module load_extract_unit #(
    parameter int ADDR_W  = 64,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [63:0]       mem_rd_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_err,
    output logic [1:0]        o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends on ready, and a raised resp_valid holds its payload until taken.

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_mem_rd_en;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_resp_valid;
    logic [63:0]         r_resp_data;
    logic [TAG_W-1:0]    r_resp_tag;
    logic                r_resp_err;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_off;
    logic [1:0]          r_size;
    logic                r_signed;
    logic [TAG_W-1:0]    r_req_tag;

    logic [2:0]          w_off;
    logic [63:0]         w_raw;
    logic [63:0]         w_ext;

    // Low address bits that must be zero for an access of the given size.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 3'b000;
            2'b01:   return 3'b001;
            2'b10:   return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    logic w_req_misaligned;
    assign w_req_misaligned = |(req_addr[2:0] & align_mask(req_size));
    assign w_off            = r_off;
`else
    // Without trapping, misaligned low bits are simply dropped so the access stays inside the doubleword.
    assign w_off = r_off & ~align_mask(r_size);
`endif

    always_comb begin
        w_raw = mem_rd_data >> {w_off, 3'b000};
        w_ext = w_raw;
        case (r_size)
            2'b00:   w_ext = {{56{r_signed & w_raw[7]}},  w_raw[7:0]};
            2'b01:   w_ext = {{48{r_signed & w_raw[15]}}, w_raw[15:0]};
            2'b10:   w_ext = {{32{r_signed & w_raw[31]}}, w_raw[31:0]};
            default: w_ext = w_raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_mem_rd_en  <= 1'b0;
            r_mem_addr   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_tag   <= '0;
            r_resp_err   <= 1'b0;
            r_cnt        <= '0;
            r_off        <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_req_tag    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_off     <= req_addr[2:0];
                        r_size    <= req_size;
                        r_signed  <= req_signed;
                        r_req_tag <= req_tag;
`ifdef MISALIGN_TRAP_EN
                        if (w_req_misaligned) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_data  <= '0;
                            r_resp_tag   <= req_tag;
                        end else begin
                            r_state     <= REQ;
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
                        end
`else
                        r_state     <= REQ;
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
`endif
                    end
                end
                REQ: begin
                    r_mem_rd_en <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (mem_rd_valid) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_data  <= w_ext;
                        r_resp_tag   <= r_req_tag;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_data  <= '0;
                        r_resp_tag   <= r_req_tag;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == IDLE) && !reset;
    assign mem_rd_en   = r_mem_rd_en;
    assign mem_addr    = r_mem_addr;
    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;
    assign resp_tag    = r_resp_tag;
    assign resp_err    = r_resp_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_load_extract_unit.sv
// Directed testbench for load_extract_unit; follows MISALIGN_TRAP_EN the same way the design does.
module tb_load_extract_unit;

  localparam int ADDR_W  = 64;
  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [1:0]        req_size = '0;
  logic              req_signed = 1'b0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_valid = 1'b0;
  logic [63:0]       mem_rd_data = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [63:0]       resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic              resp_err;
  logic [1:0]        dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int rd_en_cnt = 0;

  load_extract_unit #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed), .req_tag(req_tag),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (mem_rd_en === 1'b1) rd_en_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // driver: present one request while in IDLE; returns #1 after the accepting edge
  task automatic issue(input logic [63:0] addr, input logic [1:0] size, input logic sgn,
                       input logic [4:0] tag);
    req_addr = addr; req_size = size; req_signed = sgn; req_tag = tag; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_req_ready_during: got %0b want 0", req_ready); end
    reset = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %0b want 1", req_ready); end
    n_cmp++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_rd_en: got %0b want 0", mem_rd_en); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %0b want 0", resp_valid); end
    n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL reset_resp_err: got %0b want 0", resp_err); end
    n_cmp++; if (resp_data !== 64'h0) begin n_err++; $display("FAIL reset_resp_data: got %0h want 0", resp_data); end
    n_cmp++; if (resp_tag !== 5'h0) begin n_err++; $display("FAIL reset_resp_tag: got %0h want 0", resp_tag); end
    n_cmp++; if (mem_addr !== 64'h0) begin n_err++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(posedge clk); #1;
  endtask

  // full load with memory answering in the first WAIT cycle (minimum latency)
  task automatic do_load(input string name, input logic [63:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [4:0] tag, input logic [63:0] mdata,
                         input logic [63:0] exp_maddr, input logic [63:0] exp_data);
    rd_en_cnt = 0;
    issue(addr, size, sgn, tag);
    n_cmp++; if (mem_rd_en !== 1'b1) begin n_err++; $display("FAIL %s_rd_en_req: got %0b want 1", name, mem_rd_en); end
    n_cmp++; if (mem_addr !== exp_maddr) begin n_err++; $display("FAIL %s_mem_addr: got %0h want %0h", name, mem_addr, exp_maddr); end
    @(posedge clk); #1;
    n_cmp++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL %s_rd_en_wait: got %0b want 0", name, mem_rd_en); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL %s_early_valid: got %0b want 0", name, resp_valid); end
    mem_rd_valid = 1'b1; mem_rd_data = mdata;
    @(posedge clk); #1;
    mem_rd_valid = 1'b0; mem_rd_data = {$urandom, $urandom};
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL %s_valid: got %0b want 1", name, resp_valid); end
    n_cmp++; if (resp_data !== exp_data) begin n_err++; $display("FAIL %s_data: got %0h want %0h", name, resp_data, exp_data); end
    n_cmp++; if (resp_tag !== tag) begin n_err++; $display("FAIL %s_tag: got %0h want %0h", name, resp_tag, tag); end
    n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL %s_err: got %0b want 0", name, resp_err); end
    n_cmp++; if (rd_en_cnt != 1) begin n_err++; $display("FAIL %s_rd_en_count: got %0d want 1", name, rd_en_cnt); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL %s_valid_drop: got %0b want 0", name, resp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL %s_idle_ready: got %0b want 1", name, req_ready); end
  endtask

  task automatic test_byte_signed();
    do_load("byte_s", 64'h1003, 2'b00, 1'b1, 5'h01, 64'h00000000_80000000, 64'h1000, 64'hFFFFFFFF_FFFFFF80);
  endtask

  task automatic test_half_unsigned();
    do_load("half_u", 64'h1006, 2'b01, 1'b0, 5'h02, 64'hBEEF0000_00000000, 64'h1000, 64'h00000000_0000BEEF);
  endtask

  task automatic test_sizes();
    do_load("half_s", 64'h1002, 2'b01, 1'b1, 5'h03, 64'h00000000_80010000, 64'h1000, 64'hFFFFFFFF_FFFF8001);
    do_load("word_s", 64'h2004, 2'b10, 1'b1, 5'h04, 64'hF0000000_00000000, 64'h2000, 64'hFFFFFFFF_F0000000);
    do_load("word_u", 64'h200C, 2'b10, 1'b0, 5'h05, 64'hF0000000_00000000, 64'h2008, 64'h00000000_F0000000);
    do_load("dword_s", 64'hABCD_0008, 2'b11, 1'b1, 5'h1F, 64'h80000000_00000001, 64'hABCD_0008, 64'h80000000_00000001);
    do_load("byte_u", 64'h3007, 2'b00, 1'b0, 5'h06, 64'hA5000000_00000000, 64'h3000, 64'h00000000_000000A5);
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic trap_one(input string name, input logic [63:0] addr, input logic [1:0] size,
                          input logic [4:0] tag);
    rd_en_cnt = 0;
    issue(addr, size, 1'b0, tag);
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL %s_valid: got %0b want 1", name, resp_valid); end
    n_cmp++; if (resp_err !== 1'b1) begin n_err++; $display("FAIL %s_err: got %0b want 1", name, resp_err); end
    n_cmp++; if (resp_data !== 64'h0) begin n_err++; $display("FAIL %s_data: got %0h want 0", name, resp_data); end
    n_cmp++; if (resp_tag !== tag) begin n_err++; $display("FAIL %s_tag: got %0h want %0h", name, resp_tag, tag); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_cmp++; if (rd_en_cnt != 0) begin n_err++; $display("FAIL %s_rd_en_count: got %0d want 0", name, rd_en_cnt); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL %s_idle_ready: got %0b want 1", name, req_ready); end
  endtask

  task automatic test_misaligned();
    trap_one("mis_word", 64'h1006, 2'b10, 5'h07);
    trap_one("mis_half", 64'h1001, 2'b01, 5'h08);
    trap_one("mis_dword", 64'h1004, 2'b11, 5'h09);
  endtask
`else
  task automatic test_misaligned();
    do_load("mis_word", 64'h1006, 2'b10, 1'b0, 5'h07, 64'h12345678_00000000, 64'h1000, 64'h00000000_12345678);
    do_load("mis_half", 64'h1001, 2'b01, 1'b0, 5'h08, 64'h00000000_00001234, 64'h1000, 64'h00000000_00001234);
    do_load("mis_dword", 64'h1004, 2'b11, 1'b0, 5'h09, 64'h01234567_89ABCDEF, 64'h1000, 64'h01234567_89ABCDEF);
  endtask
`endif

  task automatic test_timeout();
    int cyc;
    issue(64'h2000, 2'b11, 1'b0, 5'h09);
    @(posedge clk); #1;
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++; if (cyc != TIMEOUT) begin n_err++; $display("FAIL timeout_cycles: got %0d want %0d", cyc, TIMEOUT); end
    n_cmp++; if (resp_err !== 1'b1) begin n_err++; $display("FAIL timeout_err: got %0b want 1", resp_err); end
    n_cmp++; if (resp_data !== 64'h0) begin n_err++; $display("FAIL timeout_data: got %0h want 0", resp_data); end
    n_cmp++; if (resp_tag !== 5'h09) begin n_err++; $display("FAIL timeout_tag: got %0h want 9", resp_tag); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL timeout_valid_drop: got %0b want 0", resp_valid); end
  endtask

  task automatic test_backpressure();
    issue(64'h1010, 2'b00, 1'b1, 5'h15);
    @(posedge clk); #1;
    mem_rd_valid = 1'b1; mem_rd_data = 64'h00000000_000000FE;
    @(posedge clk); #1;
    mem_rd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_addr = 64'h5000; req_size = 2'b11;
      n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, resp_valid); end
      n_cmp++; if (resp_data !== 64'hFFFFFFFF_FFFFFFFE) begin n_err++; $display("FAIL bp_data[%0d]: got %0h want fffffffffffffffe", i, resp_data); end
      n_cmp++; if (resp_tag !== 5'h15) begin n_err++; $display("FAIL bp_tag[%0d]: got %0h want 15", i, resp_tag); end
      n_cmp++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL bp_err[%0d]: got %0b want 0", i, resp_err); end
      n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_req_ready[%0d]: got %0b want 0", i, req_ready); end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_drop: got %0b want 0", resp_valid); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL bp_state_idle: got %0d want 0", dbg_state); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_req_ready_after: got %0b want 1", req_ready); end
  endtask

  task automatic test_reset_mid();
    issue(64'h4000, 2'b11, 1'b0, 5'h03);
    @(posedge clk); #1;
    n_cmp++; if (dbg_state !== 2'd2) begin n_err++; $display("FAIL rst_mid_in_wait: got %0d want 2", dbg_state); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_rd_valid = 1'b1; mem_rd_data = 64'h00000000_0000DEAD;
    @(posedge clk); #1;
    mem_rd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid[%0d]: got %0b want 0", i, resp_valid); end
      n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_mid_state[%0d]: got %0d want 0", i, dbg_state); end
      n_cmp++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_mid_rd_en[%0d]: got %0b want 0", i, mem_rd_en); end
      @(posedge clk); #1;
    end
    n_cmp++; if (resp_data !== 64'h0) begin n_err++; $display("FAIL rst_mid_data: got %0h want 0", resp_data); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_req_ready: got %0b want 1", req_ready); end
  endtask

  task automatic test_back_to_back();
    do_load("b2b_0", 64'h6001, 2'b00, 1'b1, 5'h0A, 64'h00000000_00007F00, 64'h6000, 64'h00000000_0000007F);
    do_load("b2b_1", 64'h6008, 2'b10, 1'b1, 5'h0B, 64'h00000000_7FFFFFFF, 64'h6008, 64'h00000000_7FFFFFFF);
  endtask

  initial begin
    test_reset();
    test_byte_signed();
    test_half_unsigned();
    test_sizes();
    test_misaligned();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
